// File: rtl/cm_multi_region.sv
// cm_multi_region
//   Configuration manager for the colour-display path. Pops command bytes from
//   a show-ahead UART receive FIFO, decodes WRITE / READ / CLEAR_ALL commands
//   over NUM_REGIONS screen regions, pushes colour writes to the colour memory
//   over a valid/ready handshake and keeps a shadow copy of every region colour.
//
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   Empty, RXD_Data            FIFO empty flag and head byte (valid when Empty=0)
//   Rd_En                      pop strobe (combinational), byte consumed at edge
//   c_addr, c_data, c_valid    colour-memory write request
//   c_ready                    colour memory accepts the write
//   Config_Status              current FSM state encoding
//   Config_Notification(_Valid){opcode, region} of a completed command + pulse
//   Read_Data                  shadow value returned by a READ
//   Config_Error, Error_Valid  error code (01 opcode, 10 region, 11 timeout) + pulse
//
// Handshake: a write transfers on every rising edge where c_valid and c_ready
// are both 1. Once c_valid rises it stays high, with c_addr/c_data frozen,
// until that transfer happens; c_ready is don't-care while c_valid is 0.
module cm_multi_region #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int NUM_REGIONS     = 4,
    parameter int c_data_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Empty,
    input  logic [UART_DATA_WIDTH-1:0] RXD_Data,
    output logic                       Rd_En,
    output logic [3:0]                 c_addr,
    output logic [c_data_WIDTH-1:0]    c_data,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic [2:0]                 Config_Status,
    output logic [5:0]                 Config_Notification,
    output logic                       Config_Notification_Valid,
    output logic [c_data_WIDTH-1:0]    Read_Data,
    output logic [1:0]                 Config_Error,
    output logic                       Error_Valid
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        WRITE     = 3'd2,
        CLEAR     = 3'd3,
        READ_RESP = 3'd4,
        ERROR     = 3'd5
    } state_t;

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_BAD   = 2'b11;

    state_t                  state;
    logic [TW-1:0]           tcnt;
    logic [3:0]              cmd_region;
    logic [c_data_WIDTH-1:0] shadow [0:NUM_REGIONS-1];

    logic [1:0] hdr_op;
    logic [3:0] hdr_region;
    logic       region_ok;
    logic       unused_hdr_bits;

    assign hdr_op     = RXD_Data[7:6];
    assign hdr_region = RXD_Data[5:2];
    assign region_ok  = (int'(hdr_region) < NUM_REGIONS);
    // Header bits [1:0] carry no meaning; folded here so they are visibly consumed.
    assign unused_hdr_bits = ^RXD_Data;

    // Popping is only legal in the two states that expect a byte; reset blocks it.
    assign Rd_En = ~rst & ~Empty & ((state == IDLE) | (state == WAIT_DATA));

    assign Config_Status = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            tcnt                      <= '0;
            cmd_region                <= '0;
            c_addr                    <= '0;
            c_data                    <= '0;
            c_valid                   <= 1'b0;
            Config_Notification       <= '0;
            Config_Notification_Valid <= 1'b0;
            Read_Data                 <= '0;
            Config_Error              <= '0;
            Error_Valid               <= 1'b0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            // Pulses default low; each state raises them for exactly one cycle.
            Config_Notification_Valid <= 1'b0;
            Error_Valid               <= 1'b0;

            case (state)
                IDLE: begin
                    if (!Empty) begin
                        case (hdr_op)
                            OP_BAD: begin
                                Config_Error <= 2'b01;
                                Error_Valid  <= 1'b1;
                                state        <= ERROR;
                            end
                            OP_CLEAR: begin
                                // Region field ignored; c_addr doubles as the sweep counter.
                                c_addr  <= '0;
                                c_data  <= '0;
                                c_valid <= 1'b1;
                                state   <= CLEAR;
                            end
                            default: begin
                                if (!region_ok) begin
                                    Config_Error <= 2'b10;
                                    Error_Valid  <= 1'b1;
                                    state        <= ERROR;
                                end else if (hdr_op == OP_WRITE) begin
                                    cmd_region <= hdr_region;
                                    tcnt       <= '0;
                                    state      <= WAIT_DATA;
                                end else begin
                                    // READ answers in the very next cycle.
                                    Read_Data                 <= shadow[hdr_region[IDX_W-1:0]];
                                    Config_Notification       <= {OP_READ, hdr_region};
                                    Config_Notification_Valid <= 1'b1;
                                    state                     <= READ_RESP;
                                end
                            end
                        endcase
                    end
                end

                WAIT_DATA: begin
                    // A byte present on the timeout cycle takes priority over the error.
                    if (!Empty) begin
                        c_addr  <= cmd_region;
                        c_data  <= RXD_Data[c_data_WIDTH-1:0];
                        c_valid <= 1'b1;
                        state   <= WRITE;
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        Config_Error <= 2'b11;
                        Error_Valid  <= 1'b1;
                        state        <= ERROR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                WRITE: begin
                    if (c_ready) begin
                        shadow[c_addr[IDX_W-1:0]] <= c_data;
                        c_valid                   <= 1'b0;
                        Config_Notification       <= {OP_WRITE, c_addr};
                        Config_Notification_Valid <= 1'b1;
                        state                     <= IDLE;
                    end
                end

                CLEAR: begin
                    if (c_ready) begin
                        shadow[c_addr[IDX_W-1:0]] <= '0;
                        if (c_addr == 4'(NUM_REGIONS - 1)) begin
                            c_valid                   <= 1'b0;
                            Config_Notification       <= {OP_CLEAR, 4'hF};
                            Config_Notification_Valid <= 1'b1;
                            state                     <= IDLE;
                        end else begin
                            c_addr <= c_addr + 4'd1;
                        end
                    end
                end

                READ_RESP: state <= IDLE;
                ERROR:     state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cm_multi_region.sv
// Directed bench for cm_multi_region (NUM_REGIONS=4, TIMEOUT_CYCLES=16).
module tb_cm_multi_region;

    localparam int NR = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       Empty;
    logic [7:0] RXD_Data;
    logic       Rd_En;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       c_valid;
    logic       c_ready;
    logic [2:0] Config_Status;
    logic [5:0] Config_Notification;
    logic       Config_Notification_Valid;
    logic [7:0] Read_Data;
    logic [1:0] Config_Error;
    logic       Error_Valid;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];   // expected {c_addr, c_data} of each handshake

    cm_multi_region #(
        .UART_DATA_WIDTH(8),
        .NUM_REGIONS(NR),
        .c_data_WIDTH(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Empty(Empty),
        .RXD_Data(RXD_Data),
        .Rd_En(Rd_En),
        .c_addr(c_addr),
        .c_data(c_data),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .Config_Status(Config_Status),
        .Config_Notification(Config_Notification),
        .Config_Notification_Valid(Config_Notification_Valid),
        .Read_Data(Read_Data),
        .Config_Error(Config_Error),
        .Error_Valid(Error_Valid)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshake scoreboard: sampled mid-low-phase, after inputs settle.
    always @(negedge clk) begin
        #2;
        if (!rst && c_valid && c_ready) begin
            if (exp_q.size() == 0) begin
                check("hs_unexpected", 32'd1, 32'd0);
            end else begin
                check("hs", {20'd0, c_addr, c_data}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    // Present a byte and return at the negedge right after it was popped.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        Empty    = 1'b0;
        RXD_Data = b;
        #1;
        while (!Rd_En && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!Rd_En) check("pop_wait", 32'd0, 32'd1);
        @(negedge clk);
        Empty = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] r, input logic [7:0] d);
        exp_q.push_back({r, d});
        push_byte({2'b00, r, 2'b00});
        push_byte(d);
        #1;
        check("wr_valid", c_valid, 1);
        check("wr_addr", c_addr, r);
        check("wr_data", c_data, d);
        @(negedge clk);
        #1;
        check("wr_valid_drop", c_valid, 0);
        check("wr_notif_v", Config_Notification_Valid, 1);
        check("wr_notif", Config_Notification, {2'b00, r});
        check("wr_status", Config_Status, 0);
    endtask

    task automatic do_read(input logic [3:0] r, input logic [7:0] exp);
        push_byte({2'b01, r, 2'b00});
        #1;
        check("rd_status", Config_Status, 4);
        check("rd_notif_v", Config_Notification_Valid, 1);
        check("rd_notif", Config_Notification, {2'b01, r});
        check("rd_data", Read_Data, exp);
    endtask

    task automatic do_err(input logic [7:0] hdr, input logic [1:0] code);
        push_byte(hdr);
        #1;
        check("err_valid", Error_Valid, 1);
        check("err_code", Config_Error, code);
        check("err_status", Config_Status, 5);
        @(negedge clk);
        #1;
        check("err_pulse_end", Error_Valid, 0);
        check("err_idle", Config_Status, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  done;
        rst      = 1'b1;
        Empty    = 1'b0;        // byte waiting: Rd_En must still stay low in reset
        RXD_Data = 8'hC0;
        c_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rd_en", Rd_En, 0);
        check("rst_status", Config_Status, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_c_addr", c_addr, 0);
        check("rst_c_data", c_data, 0);
        check("rst_notif_v", Config_Notification_Valid, 0);
        check("rst_notif", Config_Notification, 0);
        check("rst_read_data", Read_Data, 0);
        check("rst_err", Config_Error, 0);
        check("rst_err_v", Error_Valid, 0);
        @(negedge clk);
        Empty = 1'b1;
        rst   = 1'b0;
        @(negedge clk);

        // WRITE 0x08, 0x5A back to back with c_ready high
        do_write(4'd2, 8'h5A);

        // WRITE with 10 cycles of backpressure while the FIFO holds a byte
        c_ready = 1'b0;
        exp_q.push_back({4'd3, 8'hA5});
        push_byte(8'h0C);
        push_byte(8'hA5);
        Empty    = 1'b0;
        RXD_Data = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_valid", c_valid, 1);
            check("bp_addr", c_addr, 3);
            check("bp_data", c_data, 8'hA5);
            check("bp_no_pop", Rd_En, 0);
            @(negedge clk);
        end
        Empty   = 1'b1;
        c_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_valid_drop", c_valid, 0);
        check("bp_notif_v", Config_Notification_Valid, 1);
        check("bp_notif", Config_Notification, 6'h03);

        // READs of written regions
        do_read(4'd2, 8'h5A);
        do_read(4'd3, 8'hA5);
        do_read(4'd0, 8'h00);

        // Errors: bad opcode, region out of range (also for READ)
        do_err(8'hC0, 2'b01);
        do_err(8'h14, 2'b10);
        do_err(8'h50, 2'b10);

        // Timeout: header 0x04 with no data byte
        push_byte(8'h04);
        for (int i = 0; i < TO; i++) begin
            #1;
            check("to_wait", Config_Status, 1);
            check("to_no_err", Error_Valid, 0);
            @(negedge clk);
        end
        #1;
        check("to_err_valid", Error_Valid, 1);
        check("to_err_code", Config_Error, 2'b11);
        @(negedge clk);
        #1;
        check("to_idle", Config_Status, 0);

        // Byte arriving on the final timeout cycle wins
        push_byte(8'h04);
        for (int i = 0; i < TO - 1; i++) @(negedge clk);
        exp_q.push_back({4'd1, 8'h3C});
        push_byte(8'h3C);
        #1;
        check("race_no_err", Error_Valid, 0);
        check("race_status", Config_Status, 2);
        check("race_valid", c_valid, 1);
        @(negedge clk);
        #1;
        check("race_notif", Config_Notification, 6'h01);
        do_read(4'd1, 8'h3C);

        // CLEAR_ALL with c_ready toggling
        for (int i = 0; i < NR; i++) exp_q.push_back({i[3:0], 8'h00});
        c_ready = 1'b0;
        push_byte(8'h80);
        done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            c_ready = i[0];
            @(negedge clk);
            #1;
            if (Config_Notification_Valid) done = 1;
        end
        check("clr_done", done, 1);
        check("clr_notif", Config_Notification, 6'h2F);
        check("clr_valid_drop", c_valid, 0);
        c_ready = 1'b1;
        for (int i = 0; i < NR; i++) do_read(i[3:0], 8'h00);

        // Reset in the middle of a backpressured WRITE
        do_write(4'd0, 8'h11);
        c_ready = 1'b0;
        push_byte(8'h04);
        push_byte(8'h77);
        #1;
        check("mid_valid", c_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", c_valid, 0);
        check("mid_rst_status", Config_Status, 0);
        rst     = 1'b0;
        c_ready = 1'b1;
        @(negedge clk);
        do_read(4'd0, 8'h00);
        do_read(4'd1, 8'h00);

        repeat (3) @(negedge clk);
        check("hs_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cm_multi_region.md
# cm_multi_region

Parametrised configuration manager for the colour-display path. It pops command bytes from the UART receive FIFO and decodes them into write, read and clear-all commands over NUM_REGIONS screen regions. Writes go to the colour memory over a valid/ready handshake, and the block keeps a shadow copy of every region colour. Outcomes are reported on notification and error pulses.

## Interface
Parameters:
- UART_DATA_WIDTH, 8, width of one received byte (fixed 8; header format depends on it)
- NUM_REGIONS, 4, number of configurable regions, legal range 1..16
- c_data_WIDTH, 8, colour word width, must be ≤ UART_DATA_WIDTH
- TIMEOUT_CYCLES, 1024, maximum wait for the data byte, ≥ 2

Ports (reset is synchronous, active-high, single clock):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- Empty  in  1  receive FIFO empty flag
- RXD_Data  in  8  FIFO head byte (show-ahead), valid whenever Empty=0
- Rd_En  out  1  pop strobe; byte consumed at the clock edge where Rd_En=1
- c_addr  out  4  region index of the pending write
- c_data  out  c_data_WIDTH  colour of the pending write
- c_valid  out  1  write request
- c_ready  in  1  colour memory accepts the write
- Config_Status  out  3  current state encoding
- Config_Notification  out  6  {opcode[1:0], region[3:0]} of the completed command
- Config_Notification_Valid  out  1  one-cycle completion pulse
- Read_Data  out  c_data_WIDTH  shadow value returned by a READ
- Config_Error  out  2  error code: 01 bad opcode, 10 region out of range, 11 timeout
- Error_Valid  out  1  one-cycle error pulse

## Operation
- Header byte layout: [7:6] opcode, [5:2] region, [1:0] ignored.
- Opcode 00 WRITE is followed by one data byte. Colour = data[c_data_WIDTH-1:0].
- Opcode 01 READ has no data byte.
- Opcode 10 CLEAR_ALL has no data byte. It writes 0 to every region.
- Opcode 11 is illegal.
- Rd_En = ~Empty & (state==IDLE | state==WAIT_DATA). Rd_En is combinational. No byte is popped in any other state.
- State machine and Config_Status encoding:
  - IDLE(0):
    - Header accepted with opcode 11: go to ERROR with code 01.
    - Region ≥ NUM_REGIONS, opcode 00 or 01: go to ERROR with code 10.
    - WRITE: go to WAIT_DATA.
    - READ: go to READ_RESP.
    - CLEAR_ALL: go to CLEAR with counter=0. The region field is ignored.
  - WAIT_DATA(1):
    - Data byte popped: go to WRITE.
    - Timeout counter reaches TIMEOUT_CYCLES-1 with Empty=1: go to ERROR with code 11.
    - The counter resets on entry and counts only while Empty=1.
  - WRITE(2):
    - c_valid=1 with c_addr and c_data held stable.
    - On the edge where c_valid&c_ready: shadow[c_addr] is updated, Notification is pulsed, and state returns to IDLE.
  - CLEAR(3):
    - c_addr=counter, c_data=0, c_valid=1.
    - Each handshake zeroes shadow[counter] and increments counter.
    - The handshake at counter=NUM_REGIONS-1 pulses Notification {10, 4'hF} and returns to IDLE.
  - READ_RESP(4): Read_Data=shadow[region]. Notification {01, region} is pulsed. Next state IDLE.
  - ERROR(5): Error_Valid=1 for one cycle with the stored code. Next state IDLE.
- The shadow register file has NUM_REGIONS entries of c_data_WIDTH bits. It changes only on handshakes.

## Timing
- Reset values:
  - State IDLE, Rd_En=0 while rst=1.
  - c_valid, Config_Notification_Valid and Error_Valid are 0.
  - c_addr, c_data, Read_Data, Config_Notification and Config_Error are 0.
  - Config_Status is 0.
  - All shadow entries are 0.
- Reset mid-operation (WAIT_DATA, WRITE or CLEAR) aborts the command. No partial shadow update is kept beyond completed handshakes. c_valid falls at the next edge.
- WRITE latency: data byte popped at edge N, c_valid=1 from cycle N+1.
  - Best case, c_ready already high: handshake at edge N+1, Notification_Valid high in cycle N+2, c_valid=0 in cycle N+2.
- c_valid never drops without a handshake. c_addr and c_data are constant while c_valid=1. c_ready is ignored when c_valid=0.
- CLEAR with c_ready tied high takes exactly NUM_REGIONS cycles of c_valid=1.
- READ: header popped at edge N, Read_Data and Notification_Valid valid in cycle N+1.
- ERROR: Error_Valid high in the cycle after the offending header, or after the timeout edge.
- If a byte arrives in the same cycle the timeout would fire, the byte wins and no error is raised.
- Back-to-back commands: the next header can be popped in the first IDLE cycle after completion. There are no dead cycles beyond the one-cycle response states.

## Test plan
- WRITE, c_ready high: bytes 0x08 then 0x5A, 1 cycle apart → c_valid one cycle with c_addr=2, c_data=0x5A; Notification {00,2}; shadow[2]=0x5A.
- WRITE with backpressure: c_ready low 10 cycles after c_valid rises → c_valid, c_addr and c_data stable for 10 cycles, no Rd_En despite Empty=0, then one handshake.
- READ after write: 0x48 (region 2) → Read_Data=0x5A and Notification {01,2} one cycle after the pop.
- Errors:
  - 0xC0 → Error_Valid with code 01.
  - 0x14 (region 5, NUM_REGIONS=4) → code 10.
  - 0x04 with no following byte for TIMEOUT_CYCLES → code 11, state IDLE.
- CLEAR_ALL (0x80) with c_ready toggling → handshakes at c_addr 0,1,2,3 in order, all shadow entries 0, final Notification {10,F}.
- rst=1 asserted while in WRITE with c_ready low → c_valid=0 next cycle, state IDLE, all shadow entries 0.
